// File: rtl/jt12_dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt12_dac_pkg
// Purpose  : Shared definitions for the DAC feeder: the sequencer state
//            encoding and a helper that sizes the interpolation accumulator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package jt12_dac_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,   // no sample played yet, output parked at 0
      ST_RUN       = 3'd1,   // interpolating between cur and tgt
      ST_HOLD      = 3'd2,   // underrun: output frozen at last sample
      ST_MUTE_RAMP = 3'd3,   // ramping last sample down to 0
      ST_MUTED     = 3'd4    // silent, FIFO kept empty
   } dac_state_e;

   // The accumulator carries the sample scaled by 2^step_log2, so it needs
   // step_log2 extra bits above the sample width.
   function automatic int acc_width(input int width, input int step_log2);
      return width + step_log2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_dac_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jt12_dac_fifo
// Purpose  : Small synchronous FIFO buffering mixer samples ahead of the
//            interpolator. Flush empties it in one cycle and wins over
//            push/pop in the same cycle.
// Ports    : clk, rst        clock, synchronous active-high reset
//            push_i, data_i  write strobe / data (ignored when full)
//            pop_i           read strobe (ignored when empty)
//            flush_i         discard all contents
//            data_o          head entry (valid when !empty_o)
//            level_o         occupancy, 0..2^DEPTH_LOG2
//            full_o, empty_o status flags
// Revision : 1.0 - initial release
// ============================================================================
module jt12_dac_fifo #(
   parameter int WIDTH      = 12,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      data_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   output logic [WIDTH-1:0]      data_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  do_push;
   logic                  do_pop;

   // Level only reaches 2^DEPTH_LOG2 when full, so its MSB is the full flag.
   assign full_o  = level_q[DEPTH_LOG2];
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i  & ~empty_o;

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/jt12_dac_feeder.sv
`default_nettype none
// ============================================================================
// Module   : jt12_dac_feeder
// Purpose  : Rate adapter in front of the sigma-delta DAC. Buffers low-rate
//            signed samples and emits one linearly interpolated sample per
//            cen tick, holding on underrun and ramping to zero on mute.
// Ports    : clk, rst     clock, synchronous active-high reset
//            cen          DAC-rate tick, interpolator advances only when 1
//            in_valid     sample offered
//            in_data      signed sample
//            in_ready     FIFO can accept (transfer on valid & ready)
//            mute         level request: ramp to zero and flush
//            dac_din      registered interpolated sample to the DAC
//            underrun     one-clk pulse when a segment ends with no data
//            fifo_level   current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module jt12_dac_feeder
   import jt12_dac_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int DEPTH_LOG2 = 2,
   parameter int STEP_LOG2  = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cen,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_data,
   output logic                    in_ready,
   input  logic                    mute,
   output logic signed [WIDTH-1:0] dac_din,
   output logic                    underrun,
   output logic [DEPTH_LOG2:0]     fifo_level
);

   localparam int ACC_W = acc_width(WIDTH, STEP_LOG2);
   localparam int DW    = WIDTH + 1;

   dac_state_e              state_q;
   logic signed [WIDTH-1:0] cur_q;
   logic signed [WIDTH-1:0] tgt_q;
   logic signed [DW-1:0]    delta_q;
   logic signed [ACC_W-1:0] acc_q;
   logic [STEP_LOG2-1:0]    phase_q;
   logic signed [WIDTH-1:0] dac_q;
   logic                    underrun_q;

   logic signed [ACC_W-1:0] acc_d;
   logic [STEP_LOG2-1:0]    phase_d;
   logic                    seg_end;

   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_flush;
   logic signed [WIDTH-1:0] fifo_dout;
   logic                    fifo_full;
   logic                    fifo_empty;

   // Delta is sign-extended into the accumulator; after 2^STEP_LOG2 adds the
   // accumulator lands exactly on tgt scaled, so segments never drift.
   assign acc_d   = acc_q + ACC_W'(delta_q);
   assign phase_d = phase_q + 1'b1;
   assign seg_end = &phase_q;

   // Readiness depends only on registered state, never on a same-cycle pop.
   assign in_ready  = ~fifo_full && (state_q != ST_MUTE_RAMP) && (state_q != ST_MUTED);
   assign fifo_push = in_valid & in_ready;

   // FIFO pop/flush decisions; these mirror the branch taken in the FSM.
   always_comb begin
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      case (state_q)
         ST_IDLE: begin
            fifo_flush = mute;
            fifo_pop   = cen & ~mute & ~fifo_empty;
         end
         ST_RUN: begin
            if (cen && seg_end) begin
               fifo_flush = mute;
               fifo_pop   = ~mute & ~fifo_empty;
            end
         end
         ST_HOLD: begin
            if (cen) begin
               fifo_flush = mute;
               fifo_pop   = ~mute & ~fifo_empty;
            end
         end
         ST_MUTE_RAMP,
         ST_MUTED: begin
            fifo_flush = 1'b1;
         end
         default: begin
            fifo_flush = 1'b1;
         end
      endcase
   end

   jt12_dac_fifo #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  (in_data),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .data_o  (fifo_dout),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cur_q      <= '0;
         tgt_q      <= '0;
         delta_q    <= '0;
         acc_q      <= '0;
         phase_q    <= '0;
         dac_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (mute) begin
                  state_q <= ST_MUTED;
               end else if (cen && !fifo_empty) begin
                  // First segment starts from silence.
                  tgt_q   <= fifo_dout;
                  delta_q <= DW'(fifo_dout);
                  phase_q <= '0;
                  state_q <= ST_RUN;
               end
            end

            ST_RUN,
            ST_MUTE_RAMP: begin
               if (cen) begin
                  acc_q   <= acc_d;
                  phase_q <= phase_d;
                  dac_q   <= WIDTH'(acc_d >>> STEP_LOG2);
                  if (seg_end) begin
                     cur_q <= tgt_q;
                     if (state_q == ST_MUTE_RAMP) begin
                        delta_q <= '0;
                        state_q <= ST_MUTED;
                     end else if (mute) begin
                        // Mute is only honoured here so the segment completes;
                        // it also suppresses any underrun at this boundary.
                        tgt_q   <= '0;
                        delta_q <= -DW'(tgt_q);
                        state_q <= ST_MUTE_RAMP;
                     end else if (!fifo_empty) begin
                        tgt_q   <= fifo_dout;
                        delta_q <= DW'(fifo_dout) - DW'(tgt_q);
                     end else begin
                        delta_q    <= '0;
                        underrun_q <= 1'b1;
                        state_q    <= ST_HOLD;
                     end
                  end
               end
            end

            ST_HOLD: begin
               if (cen) begin
                  if (mute) begin
                     tgt_q   <= '0;
                     delta_q <= -DW'(cur_q);
                     phase_q <= '0;
                     state_q <= ST_MUTE_RAMP;
                  end else if (!fifo_empty) begin
                     tgt_q   <= fifo_dout;
                     delta_q <= DW'(fifo_dout) - DW'(cur_q);
                     phase_q <= '0;
                     state_q <= ST_RUN;
                  end
               end
            end

            ST_MUTED: begin
               cur_q   <= '0;
               tgt_q   <= '0;
               delta_q <= '0;
               acc_q   <= '0;
               phase_q <= '0;
               dac_q   <= '0;
               if (!mute) begin
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign dac_din  = dac_q;
   assign underrun = underrun_q;

endmodule
`default_nettype wire
